// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// opcode encodings and the controller state encoding.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step (LSB first) or
// restoring divide step (MSB first) on a shared 2*WIDTH accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Divide keeps the remainder in the upper half and shifts the dividend
    // out of the lower half; the quotient bit is left for the caller to merge.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh[WIDTH-1:0] - operand;
        q_bit    = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            q_bit    = (rem_sh >= {1'b0, operand});
            acc_next = {(q_bit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers,
// fixed latency of WIDTH+2 cycles from accept to result pulse.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             ready,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t state, state_next;

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, opd;
    logic [2*WIDTH-1:0] acc, step_acc;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q, sign_r, q_bit;
    logic               accept, is_div, last_iter;

    logic               is_signed, div_zero, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, hi_d, lo_d;

    assign is_div    = op_r[1];
    assign accept    = ready && start && !cancel;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (accept) state_next = ST_PREP;
            end
            ST_PREP: begin
                busy       = 1'b1;
                state_next = cancel ? ST_IDLE : ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cancel)         state_next = ST_IDLE;
                else if (last_iter) state_next = ST_FIXUP;
            end
            ST_FIXUP: begin
                busy       = 1'b1;
                state_next = cancel ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                ready      = 1'b1;
                res_valid  = 1'b1;
                state_next = accept ? ST_PREP : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A zero divisor bypasses the sign handling so the raw dividend drains
    // into the remainder and the quotient saturates to all ones.
    always_comb begin
        is_signed = !op_r[0];
        div_zero  = is_div && (b_r == '0);
        sa        = is_signed && a_r[WIDTH-1] && !div_zero;
        sb        = is_signed && b_r[WIDTH-1] && !div_zero;
        mag_a     = sa ? -a_r : a_r;
        mag_b     = sb ? -b_r : b_r;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (opd),
        .acc_next (step_acc),
        .q_bit    (q_bit)
    );

    always_comb begin
        prod = sign_q ? -acc : acc;
        quo  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_d = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            opd    <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
            end
            case (state)
                ST_PREP: begin
                    opd    <= is_div ? mag_b : mag_a;
                    acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    sign_q <= sa ^ sb;
                    sign_r <= sa;
                    cnt    <= '0;
                end
                ST_CALC: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                ST_FIXUP: begin
                    if (!cancel) begin
                        hi <= hi_d;
                        lo <= lo_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, cancel/reset
// behaviour and randomized operations against a plain-arithmetic model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cancel = 1'b0;
    logic             ready, busy, res_valid;
    logic [WIDTH-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] last_hi = '0;
    logic [WIDTH-1:0] last_lo = '0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .ready     (ready),
        .busy      (busy),
        .res_valid (res_valid),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed ops via 64-bit signed arithmetic (truncating division)
    function automatic void model(input logic [1:0] m_op, input logic [31:0] m_a,
                                  input logic [31:0] m_b,
                                  output logic [31:0] m_hi, output logic [31:0] m_lo);
        logic signed [63:0] sa, sb, r;
        logic [63:0] ua, ub, ur;
        sa = {{32{m_a[31]}}, m_a};
        sb = {{32{m_b[31]}}, m_b};
        ua = {32'h0, m_a};
        ub = {32'h0, m_b};
        m_hi = '0;
        m_lo = '0;
        case (m_op)
            OP_MULT:  begin r = sa * sb; m_hi = r[63:32]; m_lo = r[31:0]; end
            OP_MULTU: begin ur = ua * ub; m_hi = ur[63:32]; m_lo = ur[31:0]; end
            default: begin
                if (m_b == 32'h0) begin
                    m_hi = m_a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (m_op == OP_DIV) begin
                    r = sa / sb; m_lo = r[31:0];
                    r = sa % sb; m_hi = r[31:0];
                end else begin
                    ur = ua / ub; m_lo = ur[31:0];
                    ur = ua % ub; m_hi = ur[31:0];
                end
            end
        endcase
    endfunction

    // Caller must be off the clock edge; returns 1 time unit after the accept edge.
    task automatic applyStimulus(input logic [1:0] s_op, input logic [31:0] s_a, input logic [31:0] s_b);
        checkOutput("ready_before_start", 64'(ready), 64'd1);
        op    = s_op;
        a     = s_a;
        b     = s_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = $urandom();
        a     = $urandom();
        b     = $urandom();
    endtask

    task automatic wait_result(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int k;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (res_valid) break;
            k++;
        end
        checkOutput({tag, "_latency"}, 64'(k), 64'(LATENCY));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(e_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(e_lo));
        last_hi = e_hi;
        last_lo = e_lo;
    endtask

    task automatic run_model(input string tag, input logic [1:0] r_op, input logic [31:0] r_a, input logic [31:0] r_b);
        logic [31:0] e_hi, e_lo;
        model(r_op, r_a, r_b, e_hi, e_lo);
        @(negedge clk);
        applyStimulus(r_op, r_a, r_b);
        wait_result(tag, e_hi, e_lo);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 64'(res_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'(($urandom_range(0, 20)));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int seen;
        logic [31:0] e_hi, e_lo;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        resetn = 1'b1;

        @(negedge clk); applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        @(negedge clk); applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_result("multu_x2", 32'h0000_0001, 32'hFFFF_FFFE);
        @(negedge clk); applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk); applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk); applyStimulus(OP_DIVU, 32'h0000_0007, 32'h0000_0002);
        wait_result("divu_7_2", 32'h0000_0001, 32'h0000_0003);
        @(negedge clk); applyStimulus(OP_DIV, 32'h1234_5678, 32'h0000_0000);
        wait_result("div_zero", 32'h1234_5678, 32'hFFFF_FFFF);
        @(negedge clk); applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_min_m1", 32'h0000_0000, 32'h8000_0000);

        // Cancel mid-calculation: no result, HI/LO keep the previous values
        @(negedge clk); applyStimulus(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checkOutput("cancel_ready", 64'(ready), 64'd1);
        checkOutput("cancel_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checkOutput("cancel_no_valid", 64'(seen), 64'd0);
        checkOutput("cancel_hi", 64'(hi), 64'(last_hi));
        checkOutput("cancel_lo", 64'(lo), 64'(last_lo));

        // Cancel and start together in IDLE: start is ignored
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd4;
        start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        checkOutput("cs_busy", 64'(busy), 64'd0);
        checkOutput("cs_ready", 64'(ready), 64'd1);
        @(negedge clk);
        checkOutput("cs_busy_later", 64'(busy), 64'd0);

        // Asynchronous reset mid-calculation
        @(negedge clk); applyStimulus(OP_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("arst_hi", 64'(hi), 64'd0);
        checkOutput("arst_lo", 64'(lo), 64'd0);
        checkOutput("arst_ready", 64'(ready), 64'd1);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_valid", 64'(res_valid), 64'd0);
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Back-to-back: second start accepted while the first result is presented
        @(negedge clk); applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_result("b2b_first", 32'h0000_0001, 32'h0000_0000);
        model(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007, e_hi, e_lo);
        applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        wait_result("b2b_second", e_hi, e_lo);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] r_op;
            logic [31:0] r_a, r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick_operand();
            r_b  = pick_operand();
            run_model($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
